uart_rcv: RTL and testbench
===========================

UART_RCV -- requirements
Module: uart_rcv

Interface
REQ-001 Parameter BAUD_DIV, default 2604, clk cycles per bit (50 MHz / 19200 baud).
REQ-002 Parameter HALF_DIV, default 1302, clk cycles from start-bit edge to start-bit mid-point.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 RX  input  1  serial line, asynchronous to clk, idle high, 8N1, LSB first.
REQ-006 clr_rdy  input  1  single-cycle pulse from the consumer acknowledging the byte; also clears error flags.
REQ-007 rx_data  output  8  last correctly framed byte.
REQ-008 rdy  output  1  new byte valid in rx_data; held until cleared.
REQ-009 frm_err  output  1  sticky: stop bit sampled low.
REQ-010 ovr_err  output  1  sticky: byte completed while rdy still set.

Function
REQ-011 RX SHALL pass through a two-flop synchronizer; a third flop holds the previous synchronized value; all logic uses only synchronized values.
REQ-012 Start detection SHALL require a falling edge: previous synchronized value 1, current value 0; a steady low line SHALL NOT start a frame.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP; the encoding is free; unreachable encodings SHALL return to IDLE.
REQ-014 IDLE: on start edge, load the baud counter with HALF_DIV and go to START; otherwise hold, with the counter frozen.
REQ-015 The baud counter SHALL count down by 1 per cycle outside IDLE; a sample event occurs in the cycle the counter reaches 0, and the counter reloads BAUD_DIV in that cycle.
REQ-016 START sample: if the line is 0, clear bit_cnt and go to DATA; if 1, treat it as a glitch and go to IDLE with no flag change.
REQ-017 DATA sample: shift the line into shift_reg MSB and shift right, so the first data bit ends in bit 0; increment bit_cnt; after the 8th sample go to STOP.
REQ-018 STOP sample, line 1: rx_data <= shift_reg and rdy <= 1; if rdy was already 1, ovr_err <= 1 and rx_data is still overwritten.
REQ-019 STOP sample, line 0: frm_err <= 1, while rx_data and rdy are unchanged.
REQ-020 STOP sample: in either case go to IDLE in the same cycle; a new start needs a fresh falling edge, so a break (RX held low) produces exactly one frm_err and no retrigger.
REQ-021 clr_rdy SHALL clear rdy, frm_err and ovr_err the next cycle; if it coincides with a set event, the set SHALL win.
REQ-022 Latency: rdy SHALL rise HALF_DIV + 9*BAUD_DIV (24738 at defaults) cycles after the RX pin falling edge, +3/-0 cycles for synchronizer delay.
REQ-023 bit_cnt SHALL be 4 bits wide and the baud counter at least 12 bits wide; no wrap-around SHALL occur within legal parameter values.
REQ-024 Back-to-back frames, with the stop bit immediately followed by the next start bit, SHALL be received with no lost byte.

Reset
REQ-025 On rst_n low: state IDLE, rx_data 0x00, rdy 0, frm_err 0, ovr_err 0, shift_reg 0x00, bit_cnt 0, baud counter HALF_DIV.
REQ-026 Synchronizer and previous-value flops SHALL reset to 0, so a frame in progress at reset release is ignored until RX returns high.
REQ-027 Reset asserted mid-frame SHALL abort the frame without setting any flag; behaviour SHALL be correct from the first full frame after release.

Verification
REQ-028 Send 0xA5 as 8N1 at BAUD_DIV -> rdy rises 24738..24741 cycles after the start edge, rx_data = 0xA5, frm_err = ovr_err = 0.
REQ-029 Send 0x3C then 0xC3 back-to-back, pulsing clr_rdy after the first -> two rdy events, rx_data 0x3C then 0xC3, no errors.
REQ-030 Send 0x55 then 0x66 with no clr_rdy -> rx_data = 0x66, rdy = 1, ovr_err = 1; a clr_rdy pulse then gives all three flags 0 next cycle.
REQ-031 Send 0x81 with the stop bit driven 0 -> frm_err = 1, rdy = 0, rx_data unchanged; hold RX low 5 bit times -> no further activity; release and send 0x12 -> rx_data = 0x12.
REQ-032 Apply a 600-cycle low glitch on idle RX -> state returns to IDLE, no flag or data change; the next valid 0xF0 is received correctly.
REQ-033 Assert rst_n low during data bit 4 of 0x77 -> all outputs at reset values; after release, 0x99 is received correctly with no errors.

Source files
------------

// File: rtl/uart_rcv_if.sv
// Byte-side handshake of the UART receiver: serial line in, received byte
// plus ready/error flags out, and the consumer's acknowledge pulse.
interface uart_rcv_if;
   logic       RX;
   logic       clr_rdy;
   logic [7:0] rx_data;
   logic       rdy;
   logic       frm_err;
   logic       ovr_err;

   modport slave (
      input  RX,
      input  clr_rdy,
      output rx_data,
      output rdy,
      output frm_err,
      output ovr_err
   );

   modport master (
      output RX,
      output clr_rdy,
      input  rx_data,
      input  rdy,
      input  frm_err,
      input  ovr_err
   );
endinterface

// File: rtl/uart_rcv.sv
// 8N1 UART receiver: synchronised RX, mid-bit sampling from a down-counting
// baud counter, held ready flag with sticky framing/overrun errors.
module uart_rcv #(
   parameter int BAUD_DIV = 2604,
   parameter int HALF_DIV = 1302
) (
   input  logic        clk,
   input  logic        rst_n,
   uart_rcv_if.slave   uart_io
);

   localparam int CW = ($clog2(BAUD_DIV + 1) > 12) ? $clog2(BAUD_DIV + 1) : 12;
   localparam logic [CW-1:0] BAUD_LOAD = CW'(BAUD_DIV);
   localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_DIV);
   localparam logic [CW-1:0] ONE_CNT   = CW'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_e;

   logic          sync1_q, sync2_q, prev_q;
   state_e        state_q, state_d;
   logic [CW-1:0] baud_q, baud_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    rx_data_q, rx_data_d;
   logic          rdy_q, rdy_d;
   logic          frm_q, frm_d;
   logic          ovr_q, ovr_d;
   logic          start_edge_s;
   logic          tick_s;

   assign start_edge_s = prev_q & ~sync2_q;
   // The sample fires on the cycle the count would reach zero; reloading there keeps the period at BAUD_DIV.
   assign tick_s       = (baud_q == ONE_CNT);

   // Next-state and flag update for the receive FSM.
   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      rx_data_d = rx_data_q;
      rdy_d     = rdy_q;
      frm_d     = frm_q;
      ovr_d     = ovr_q;

      if (uart_io.clr_rdy) begin
         rdy_d = 1'b0;
         frm_d = 1'b0;
         ovr_d = 1'b0;
      end else begin
         rdy_d = rdy_q;
      end

      if (state_q != ST_IDLE) begin
         if (tick_s) begin
            baud_d = BAUD_LOAD;
         end else begin
            baud_d = baud_q - ONE_CNT;
         end
      end else begin
         baud_d = baud_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (start_edge_s) begin
               baud_d  = HALF_LOAD;
               state_d = ST_START;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            if (tick_s) begin
               if (!sync2_q) begin
                  bit_cnt_d = 4'd0;
                  state_d   = ST_DATA;
               end else begin
                  state_d   = ST_IDLE;
               end
            end else begin
               state_d = ST_START;
            end
         end
         ST_DATA: begin
            if (tick_s) begin
               shift_d   = {sync2_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd7) begin
                  state_d = ST_STOP;
               end else begin
                  state_d = ST_DATA;
               end
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_STOP: begin
            if (tick_s) begin
               // Set events override a coincident clr_rdy.
               if (sync2_q) begin
                  rx_data_d = shift_q;
                  rdy_d     = 1'b1;
                  if (rdy_q) begin
                     ovr_d = 1'b1;
                  end else begin
                     ovr_d = ovr_d;
                  end
               end else begin
                  frm_d = 1'b1;
               end
               state_d = ST_IDLE;
            end else begin
               state_d = ST_STOP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, synchroniser and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         prev_q    <= 1'b0;
         state_q   <= ST_IDLE;
         baud_q    <= HALF_LOAD;
         bit_cnt_q <= 4'd0;
         shift_q   <= 8'h00;
         rx_data_q <= 8'h00;
         rdy_q     <= 1'b0;
         frm_q     <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         sync1_q   <= uart_io.RX;
         sync2_q   <= sync1_q;
         prev_q    <= sync2_q;
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         rx_data_q <= rx_data_d;
         rdy_q     <= rdy_d;
         frm_q     <= frm_d;
         ovr_q     <= ovr_d;
      end
   end

   assign uart_io.rx_data = rx_data_q;
   assign uart_io.rdy     = rdy_q;
   assign uart_io.frm_err = frm_q;
   assign uart_io.ovr_err = ovr_q;

endmodule

// File: tb/tb_uart_rcv.sv
// Directed bench for uart_rcv with a short baud divider; each check compares
// the receiver outputs to hand-computed expectations.
module tb_uart_rcv;

   localparam int B = 16;
   localparam int H = 8;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;
   int   lat;

   uart_rcv_if bus ();

   uart_rcv #(.BAUD_DIV(B), .HALF_DIV(H)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .uart_io (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called on a negedge; drives one 8N1 frame, leaving RX at the stop level.
   task automatic send_byte(input logic [7:0] data, input logic stop_val);
      bus.RX = 1'b0;
      repeat (B) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         bus.RX = data[i];
         repeat (B) @(negedge clk);
      end
      bus.RX = stop_val;
      repeat (B) @(negedge clk);
   endtask

   task automatic wait_rdy(input string tag, input int limit, output int cyc);
      cyc = 0;
      while (!bus.rdy && cyc < limit) begin
         @(negedge clk);
         cyc++;
      end
      check_eq(tag, 32'(cyc < limit), 32'd1);
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      bus.clr_rdy = 1'b1;
      @(negedge clk);
      bus.clr_rdy = 1'b0;
   endtask

   task automatic check_flags(input string tag, input logic [7:0] data,
                              input logic rdy, input logic frm, input logic ovr);
      check_eq({tag, "_data"}, 32'(bus.rx_data), 32'(data));
      check_eq({tag, "_rdy"},  32'(bus.rdy),     32'(rdy));
      check_eq({tag, "_frm"},  32'(bus.frm_err), 32'(frm));
      check_eq({tag, "_ovr"},  32'(bus.ovr_err), 32'(ovr));
   endtask

   initial begin
      n_tests     = 0;
      n_fail      = 0;
      bus.RX      = 1'b1;
      bus.clr_rdy = 1'b0;
      rst_n       = 1'b0;
      repeat (4) @(negedge clk);
      check_flags("reset", 8'h00, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      repeat (2 * B) @(negedge clk);
      check_flags("idle", 8'h00, 1'b0, 1'b0, 1'b0);

      // Single byte with latency measured from the pin edge.
      fork
         send_byte(8'hA5, 1'b1);
         wait_rdy("a5_wait", 400, lat);
      join
      $display("[TB] 0xA5 latency %0d cycles", lat);
      check_eq("a5_lat_in_window", 32'(lat >= H + 9 * B && lat <= H + 9 * B + 3), 32'd1);
      check_flags("a5", 8'hA5, 1'b1, 1'b0, 1'b0);
      pulse_clr();
      check_flags("a5_clr", 8'hA5, 1'b0, 1'b0, 1'b0);

      // Back-to-back frames with the consumer acknowledging the first.
      fork
         begin
            send_byte(8'h3C, 1'b1);
            send_byte(8'hC3, 1'b1);
         end
         begin
            wait_rdy("b2b1_wait", 400, lat);
            check_eq("b2b1_data", 32'(bus.rx_data), 32'h3C);
            pulse_clr();
            check_eq("b2b1_cleared", 32'(bus.rdy), 32'd0);
            wait_rdy("b2b2_wait", 400, lat);
            check_eq("b2b2_data", 32'(bus.rx_data), 32'hC3);
         end
      join
      check_flags("b2b_end", 8'hC3, 1'b1, 1'b0, 1'b0);
      pulse_clr();

      // Overrun: second byte lands while rdy still set.
      @(negedge clk);
      send_byte(8'h55, 1'b1);
      send_byte(8'h66, 1'b1);
      check_flags("ovr", 8'h66, 1'b1, 1'b0, 1'b1);
      pulse_clr();
      check_flags("ovr_clr", 8'h66, 1'b0, 1'b0, 1'b0);

      // Framing error, then a held break must not retrigger.
      send_byte(8'h81, 1'b0);
      check_flags("frm", 8'h66, 1'b0, 1'b1, 1'b0);
      pulse_clr();
      repeat (5 * B) @(negedge clk);
      check_flags("break", 8'h66, 1'b0, 1'b0, 1'b0);
      bus.RX = 1'b1;
      repeat (B) @(negedge clk);
      send_byte(8'h12, 1'b1);
      check_flags("after_break", 8'h12, 1'b1, 1'b0, 1'b0);
      pulse_clr();

      // Short low glitch on the idle line is rejected at the start sample.
      bus.RX = 1'b0;
      repeat (H / 2) @(negedge clk);
      bus.RX = 1'b1;
      repeat (12 * B) @(negedge clk);
      check_flags("glitch", 8'h12, 1'b0, 1'b0, 1'b0);
      send_byte(8'hF0, 1'b1);
      check_flags("f0", 8'hF0, 1'b1, 1'b0, 1'b0);
      pulse_clr();

      // Reset in data bit 4 of 0x77, with RX low across the release.
      bus.RX = 1'b0;
      repeat (B) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         bus.RX = (i != 3);
         repeat (B) @(negedge clk);
      end
      bus.RX = 1'b1;
      repeat (B / 2) @(negedge clk);
      rst_n  = 1'b0;
      repeat (2) @(negedge clk);
      check_flags("midreset", 8'h00, 1'b0, 1'b0, 1'b0);
      bus.RX = 1'b0;
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      repeat (12 * B) @(negedge clk);
      check_flags("low_at_release", 8'h00, 1'b0, 1'b0, 1'b0);
      bus.RX = 1'b1;
      repeat (B) @(negedge clk);
      send_byte(8'h99, 1'b1);
      check_flags("after_reset", 8'h99, 1'b1, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
